// File: rtl/div_ctrl_if.sv
// Bundle between the execute stage, the div_ctrl sequencer and the iterative divider.
// Handshake: a request is taken when req_valid_i is high in IDLE with flush_i low; the
// divider runs while div_start_o is high and signals completion with div_ready_i.
interface div_ctrl_if;
  logic        req_valid_i;
  logic [3:0]  req_op_i;
  logic [31:0] req_dividend_i;
  logic [31:0] req_divisor_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        hold_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        div_start_o;
  logic [3:0]  div_op_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  logic [1:0]  state_dbg;

  modport slave (
    input  req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_rd_i, flush_i,
    input  div_result_i, div_ready_i,
    output hold_o, wb_valid_o, wb_rd_o, wb_data_o,
    output div_start_o, div_op_o, div_dividend_o, div_divisor_o, state_dbg
  );

  modport master (
    output req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_rd_i, flush_i,
    output div_result_i, div_ready_i,
    input  hold_o, wb_valid_o, wb_rd_o, wb_data_o,
    input  div_start_o, div_op_o, div_dividend_o, div_divisor_o, state_dbg
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer owning the iterative divider's start/ready handshake, with a one-entry
// result cache so a repeated identical divide/remainder completes without the divider.
module div_ctrl #(
  parameter bit CACHE_EN = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  div_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  logic [1:0]  state, state_n;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic [3:0]  op_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic [4:0]  rd_q;

  logic        c_valid;
  logic [3:0]  c_op;
  logic [31:0] c_dividend;
  logic [31:0] c_divisor;
  logic [31:0] c_result;

  logic        hit;
  logic        accept;
  logic        done;
  logic        hold;

  // The op is part of the key, so DIV and REM on the same operands never alias.
  assign hit = CACHE_EN && c_valid && (bus.req_op_i == c_op) &&
               (bus.req_dividend_i == c_dividend) && (bus.req_divisor_i == c_divisor);

  assign accept = (state == IDLE) && bus.req_valid_i && !bus.flush_i;
  assign done   = (state == BUSY) && bus.div_ready_i && !bus.flush_i;

  always_comb begin
    state_n = state;
    hold    = 1'b0;
    case (state)
      IDLE: begin
        hold = accept && !hit;
        if (accept && !hit) state_n = BUSY;
      end
      BUSY: begin
        hold = !bus.div_ready_i || bus.flush_i;
        if (bus.div_ready_i || bus.flush_i) state_n = RECOVER;
      end
      RECOVER: begin
        hold    = bus.req_valid_i && !bus.flush_i;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      c_valid    <= 1'b0;
      c_op       <= '0;
      c_dividend <= '0;
      c_divisor  <= '0;
      c_result   <= '0;
    end else begin
      state      <= state_n;
      wb_valid_q <= 1'b0;
      if (accept && hit) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= c_result;
        wb_rd_q    <= bus.req_rd_i;
      end
      if (accept && !hit) begin
        op_q       <= bus.req_op_i;
        dividend_q <= bus.req_dividend_i;
        divisor_q  <= bus.req_divisor_i;
        rd_q       <= bus.req_rd_i;
      end
      // A flush in the ready cycle wins: nothing is written back or cached.
      if (done) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= bus.div_result_i;
        wb_rd_q    <= rd_q;
        if (CACHE_EN) begin
          c_valid    <= 1'b1;
          c_op       <= op_q;
          c_dividend <= dividend_q;
          c_divisor  <= divisor_q;
          c_result   <= bus.div_result_i;
        end
      end
    end
  end

  // Start drops combinationally with ready so the divider cannot relaunch.
  assign bus.div_start_o    = (state == BUSY) && !bus.div_ready_i && !bus.flush_i;
  assign bus.div_op_o       = op_q;
  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;
  assign bus.hold_o         = hold;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_rd_o        = wb_rd_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a behavioural iterative divider answers start with ready
// after a fixed latency; expected writeback values are hand-computed constants.
module tb_div_ctrl;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0010;
  localparam logic [3:0] OP_REMU = 4'b0001;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam int DIV_LAT = 34;
  localparam int BOUND   = 100;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   div_cnt;

  div_ctrl_if bus ();

  div_ctrl #(.CACHE_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension divide semantics, used only by the divider stand-in.
  function automatic logic [31:0] div_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: r = (b == 0) ? a : a % b;
      OP_DIV:  r = (b == 0) ? 32'hFFFF_FFFF :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a :
                   32'($signed(a) / $signed(b));
      OP_REM:  r = (b == 0) ? a :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 :
                   32'($signed(a) % $signed(b));
      default: r = '0;
    endcase
    return r;
  endfunction

  // Divider stand-in: ready rises DIV_LAT cycles after start, clears once start drops.
  always @(posedge clk) begin
    if (!bus.div_start_o) begin
      div_cnt          <= 0;
      bus.div_ready_i  <= 1'b0;
    end else if (div_cnt == DIV_LAT) begin
      bus.div_ready_i  <= 1'b1;
      bus.div_result_i <= div_model(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o);
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    bus.req_valid_i    = 1'b1;
    bus.req_op_i       = op;
    bus.req_dividend_i = a;
    bus.req_divisor_i  = b;
    bus.req_rd_i       = rd;
  endtask

  // Wait for divider ready; checks start stayed high throughout. Leaves time at ready cycle.
  task automatic wait_ready(input string tag);
    bit start_ok;
    bit seen;
    start_ok = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      #1;
      if (bus.div_ready_i) begin
        seen = 1'b1;
        break;
      end
      if (!bus.div_start_o) start_ok = 1'b0;
      tick();
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_start_held"}, 32'(start_ok), 32'd1);
  endtask

  task automatic run_miss(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    drive_req(op, a, b, rd);
    #1;
    check({tag, "_hold_accept"}, 32'(bus.hold_o), 32'd1);
    tick();
    bus.req_valid_i = 1'b0;
    wait_ready(tag);
    check({tag, "_hold_fall"}, 32'(bus.hold_o), 32'd0);
    check({tag, "_start_low"}, 32'(bus.div_start_o), 32'd0);
    tick();
    check({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd1);
    check({tag, "_wb_rd"}, 32'(bus.wb_rd_o), 32'(rd));
    check({tag, "_wb_data"}, bus.wb_data_o, exp);
    check({tag, "_recover"}, 32'(bus.state_dbg), 32'(S_RECOVER));
    tick();
    check({tag, "_wb_pulse"}, 32'(bus.wb_valid_o), 32'd0);
    check({tag, "_idle"}, 32'(bus.state_dbg), 32'(S_IDLE));
  endtask

  task automatic run_hit(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    drive_req(op, a, b, rd);
    #1;
    check({tag, "_hold"}, 32'(bus.hold_o), 32'd0);
    check({tag, "_no_start"}, 32'(bus.div_start_o), 32'd0);
    tick();
    bus.req_valid_i = 1'b0;
    check({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd1);
    check({tag, "_wb_rd"}, 32'(bus.wb_rd_o), 32'(rd));
    check({tag, "_wb_data"}, bus.wb_data_o, exp);
    check({tag, "_idle"}, 32'(bus.state_dbg), 32'(S_IDLE));
    check({tag, "_no_start2"}, 32'(bus.div_start_o), 32'd0);
    tick();
    check({tag, "_wb_pulse"}, 32'(bus.wb_valid_o), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_op_i       = '0;
    bus.req_dividend_i = '0;
    bus.req_divisor_i  = '0;
    bus.req_rd_i       = '0;
    bus.flush_i        = 1'b0;
    bus.div_ready_i    = 1'b0;
    bus.div_result_i   = '0;
    repeat (3) tick();

    check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("rst_hold", 32'(bus.hold_o), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd_o), 32'd0);
    check("rst_wb_data", bus.wb_data_o, 32'd0);
    check("rst_start", 32'(bus.div_start_o), 32'd0);
    check("rst_op", 32'(bus.div_op_o), 32'd0);
    check("rst_dividend", bus.div_dividend_o, 32'd0);
    check("rst_divisor", bus.div_divisor_o, 32'd0);
    rst_n = 1'b1;
    tick();

    run_miss("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
    run_hit("divu_hit", OP_DIVU, 32'd100, 32'd7, 5'd6, 32'd14);
    run_miss("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd7, 32'd2);
    run_miss("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD);
    run_miss("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF);
    run_miss("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 5'd10, 32'hFFFF_FFFF);

    // Flush ten cycles into a miss.
    drive_req(OP_DIV, 32'd1000, 32'd3, 5'd11);
    tick();
    bus.req_valid_i = 1'b0;
    repeat (9) tick();
    bus.flush_i = 1'b1;
    #1;
    check("flush_start_low", 32'(bus.div_start_o), 32'd0);
    check("flush_hold", 32'(bus.hold_o), 32'd1);
    tick();
    bus.flush_i = 1'b0;
    check("flush_no_wb", 32'(bus.wb_valid_o), 32'd0);
    check("flush_recover", 32'(bus.state_dbg), 32'(S_RECOVER));
    tick();
    check("flush_no_wb2", 32'(bus.wb_valid_o), 32'd0);
    check("flush_idle", 32'(bus.state_dbg), 32'(S_IDLE));
    run_hit("cache_kept", OP_DIVU, 32'h0000_1234, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run_miss("div_1000_3", OP_DIV, 32'd1000, 32'd3, 5'd13, 32'd333);

    // Flush in idle is ignored.
    drive_req(OP_DIVU, 32'd9, 32'd3, 5'd1);
    bus.flush_i = 1'b1;
    #1;
    check("idle_flush_hold", 32'(bus.hold_o), 32'd0);
    tick();
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    check("idle_flush_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("idle_flush_no_wb", 32'(bus.wb_valid_o), 32'd0);

    // Flush and ready in the same cycle.
    drive_req(OP_DIVU, 32'd50, 32'd5, 5'd3);
    tick();
    bus.req_valid_i = 1'b0;
    wait_ready("fr");
    bus.flush_i = 1'b1;
    #1;
    check("fr_start_low", 32'(bus.div_start_o), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    check("fr_no_wb", 32'(bus.wb_valid_o), 32'd0);
    check("fr_recover", 32'(bus.state_dbg), 32'(S_RECOVER));
    tick();
    check("fr_idle", 32'(bus.state_dbg), 32'(S_IDLE));
    check("fr_no_wb2", 32'(bus.wb_valid_o), 32'd0);
    run_miss("fr_retry", OP_DIVU, 32'd50, 32'd5, 5'd3, 32'd10);

    // Reset in the middle of BUSY.
    drive_req(OP_DIVU, 32'd77, 32'd7, 5'd4);
    tick();
    bus.req_valid_i = 1'b0;
    repeat (5) tick();
    check("mid_busy_start", 32'(bus.div_start_o), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mrst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("mrst_start", 32'(bus.div_start_o), 32'd0);
    check("mrst_hold", 32'(bus.hold_o), 32'd0);
    check("mrst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("mrst_wb_rd", 32'(bus.wb_rd_o), 32'd0);
    check("mrst_wb_data", bus.wb_data_o, 32'd0);
    check("mrst_op", 32'(bus.div_op_o), 32'd0);
    check("mrst_dividend", bus.div_dividend_o, 32'd0);
    check("mrst_divisor", bus.div_divisor_o, 32'd0);
    rst_n = 1'b1;
    tick();
    run_miss("post_rst_cache", OP_DIVU, 32'd50, 32'd5, 5'd3, 32'd10);
    run_miss("reissue", OP_DIVU, 32'd77, 32'd7, 5'd4, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencer that sits between the execute stage and the iterative divider and owns the divider's start/ready handshake.
- Accepts one divide/remainder request at a time and holds the pipeline while the divider runs.
- Returns the result on a one-cycle writeback pulse tagged with the destination register.
- Keeps a one-entry result cache so that a repeated identical operation completes without using the divider.
- Handles flush (jump/interrupt) by aborting the divider cleanly.

Parameters:
CACHE_EN, 1, 1 enables the one-entry result cache; 0 forces every request to use the divider.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid_i  in  1  execute stage presents a div-class instruction
req_op_i  in  4  one-hot op: [3]=DIV [2]=DIVU [1]=REM [0]=REMU
req_dividend_i  in  32  dividend (rs1)
req_divisor_i  in  32  divisor (rs2)
req_rd_i  in  5  destination register index
flush_i  in  1  pipeline flush; cancels any request in flight
hold_o  out  1  stall request to the pipeline control
wb_valid_o  out  1  one-cycle writeback strobe
wb_rd_o  out  5  writeback register index
wb_data_o  out  32  writeback data
div_start_o  out  1  divider start; must stay high for the whole operation
div_op_o  out  4  op to divider, same one-hot encoding as req_op_i
div_dividend_o  out  32  dividend to divider
div_divisor_o  out  32  divisor to divider
div_result_i  in  32  divider result
div_ready_i  in  1  divider done

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; cache valid=0.
  - hold_o=0, wb_valid_o=0, wb_rd_o=0, wb_data_o=0.
  - div_start_o=0, div_op_o=0, div_dividend_o=0, div_divisor_o=0.
- States: IDLE, BUSY, RECOVER.
- Cache hit:
  - hit = CACHE_EN && cache_valid && req_op_i==c_op && req_dividend_i==c_dividend && req_divisor_i==c_divisor.
  - The comparison is exact; the op is part of the key, so DIV and REM on the same operands are different entries.
- IDLE, req_valid_i=1, flush_i=0:
  - On a hit: wb_valid_o=1 next cycle, wb_data_o=c_result, wb_rd_o=req_rd_i. State stays IDLE. hold_o=0. The divider is not started.
  - On a miss: latch op, operands and rd into the registers that drive the div_* outputs; go to BUSY. hold_o=1 combinationally in this cycle.
- BUSY:
  - div_start_o = (state==BUSY) && !div_ready_i && !flush_i. This is combinational, so the divider sees start low in the cycle it reports ready and therefore cannot restart.
  - hold_o = !div_ready_i || flush_i.
  - div_ready_i=1 and flush_i=0:
    - Register wb_valid_o=1, wb_data_o=div_result_i, wb_rd_o=latched rd.
    - If CACHE_EN, write the cache entry and set cache_valid=1.
    - Go to RECOVER.
  - flush_i=1: discard. No wb_valid_o and no cache write, even if div_ready_i=1 in the same cycle (flush wins). Go to RECOVER.
- RECOVER (exactly 1 cycle):
  - div_start_o=0, so the divider returns to idle and clears its ready.
  - Requests are not accepted; hold_o = req_valid_i && !flush_i.
  - Next state IDLE.
- wb_valid_o is high for exactly one cycle per completed request. Any cycle with no completion drives wb_valid_o=0; wb_data_o and wb_rd_o hold their last values.
- Divide-by-zero and signed overflow are passed through from the divider unchanged; the controller adds no special case.
- Latency:
  - Hit: wb one cycle after the request.
  - Miss: wb one cycle after the divider's ready, about 36 cycles after acceptance.
  - Back-to-back misses: at least one RECOVER cycle between them.
- Flush in IDLE: the request is ignored, hold_o=0.
- Cache entry survives flush. Only reset clears it.
- Reset mid-operation: synchronous reset returns state to IDLE and deasserts div_start_o on the same edge.

Test Plan:
- DIVU 100/7, rd=5 -> div_start_o high until ready; wb_valid_o pulse with wb_rd_o=5, wb_data_o=14; hold_o falls in the cycle ready=1.
- Repeat DIVU 100/7, rd=6 -> div_start_o stays 0; wb_valid_o next cycle with data 14, rd 6. Then REMU 100/7 -> miss, wb_data_o=2.
- DIV 0xFFFFFFF9/2 -> wb_data_o=0xFFFFFFFD. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF.
- Flush 10 cycles into DIV 1000/3 -> no wb_valid_o; div_start_o low that cycle; cache unchanged. A following DIV 1000/3 -> miss, completes with 333.
- flush_i and div_ready_i both high in the same cycle -> no wb_valid_o, no cache write; next cycle is RECOVER, then IDLE.
- rst_n low mid-BUSY -> next cycle all outputs 0, state IDLE, cache invalid. The same request reissued -> full divider run gives the correct result.
